ft2232h_bus_arbiter: RTL

- Owns the FT2232H asynchronous FT245 FIFO bus and shares it between a read requester (host->FPGA bytes) and a write requester (FPGA->host bytes).
- Generates usb_rdn/usb_wrn strobes with parameterised cycle timing, controls the data-bus output enable, and arbitrates round-robin when both directions are pending.
- Sits between the FT2232H pins/IO buffer and the opcode decoder and TX data source.

---
 rtl/ft2232h_bus_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ft2232h_bus_arbiter.sv
// FT2232H FT245 asynchronous FIFO bus arbiter: round-robin between host->FPGA reads and
// FPGA->host writes. Optional macro FT_INPUT_SYNC_EN adds a flag synchroniser stage.
module ft2232h_bus_arbiter #(
    parameter int unsigned RD_LOW_CYC   = 3,
    parameter int unsigned WR_LOW_CYC   = 3,
    parameter int unsigned RECOVERY_CYC = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] usb_d_in,
    output logic [7:0] usb_d_out,
    output logic       usb_d_oe,
    input  logic       usb_rxfn,
    input  logic       usb_txen,
    output logic       usb_rdn,
    output logic       usb_wrn,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready
);

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWrSetup,
        StWr,
        StWrHold,
        StRec
    } state_e;

    typedef enum logic {
        GrantRx,
        GrantTx
    } grant_e;

    localparam logic [3:0] RdLast  = 4'(RD_LOW_CYC - 1);
    localparam logic [3:0] WrLast  = 4'(WR_LOW_CYC - 1);
    localparam logic [3:0] RecLast = 4'(RECOVERY_CYC - 1);

    state_e     state_q, state_d;
    grant_e     last_grant_q, last_grant_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rdn_q, rdn_d;
    logic       wrn_q, wrn_d;
    logic       oe_q, oe_d;
    logic [7:0] d_out_q, d_out_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;

    logic       rxf_s, txe_s;
    logic       rx_req, tx_req;
    logic       grant_rd, grant_wr;

    // Flags are asynchronous to clk; idle (high) while in reset.
`ifdef FT_INPUT_SYNC_EN
    // Meta flop plus rxf_s/txe_s form a two-flop synchroniser.
    logic rxf_meta_q, txe_meta_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rxf_meta_q <= 1'b1;
            txe_meta_q <= 1'b1;
            rxf_s      <= 1'b1;
            txe_s      <= 1'b1;
        end else begin
            rxf_meta_q <= usb_rxfn;
            txe_meta_q <= usb_txen;
            rxf_s      <= rxf_meta_q;
            txe_s      <= txe_meta_q;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            rxf_s <= 1'b1;
            txe_s <= 1'b1;
        end else begin
            rxf_s <= usb_rxfn;
            txe_s <= usb_txen;
        end
    end
`endif

    assign rx_req = !rxf_s && rx_ready;
    assign tx_req = !txe_s && tx_valid;

    // With both pending, the direction not granted last time wins.
    assign grant_rd = (state_q == StIdle) && rx_req && (!tx_req || last_grant_q == GrantTx);
    assign grant_wr = (state_q == StIdle) && tx_req && (!rx_req || last_grant_q == GrantRx);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        rdn_d        = 1'b1;
        wrn_d        = 1'b1;
        oe_d         = 1'b0;
        d_out_d      = d_out_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = 4'd0;
                if (grant_rd) begin
                    state_d      = StRd;
                    rdn_d        = 1'b0;
                    last_grant_d = GrantRx;
                end else if (grant_wr) begin
                    state_d      = StWrSetup;
                    oe_d         = 1'b1;
                    d_out_d      = tx_data;
                    last_grant_d = GrantTx;
                end
            end
            StRd: begin
                if (cnt_q == RdLast) begin
                    // Capture on the edge that also raises rdn.
                    rx_data_d  = usb_d_in;
                    rx_valid_d = 1'b1;
                    state_d    = StRec;
                    cnt_d      = 4'd0;
                end else begin
                    rdn_d = 1'b0;
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StWrSetup: begin
                state_d = StWr;
                wrn_d   = 1'b0;
                oe_d    = 1'b1;
                cnt_d   = 4'd0;
            end
            StWr: begin
                oe_d = 1'b1;
                if (cnt_q == WrLast) begin
                    state_d = StWrHold;
                    cnt_d   = 4'd0;
                end else begin
                    wrn_d = 1'b0;
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StWrHold: begin
                state_d = StRec;
                cnt_d   = 4'd0;
            end
            StRec: begin
                if (cnt_q == RecLast) begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= GrantTx;
            cnt_q        <= 4'd0;
            rdn_q        <= 1'b1;
            wrn_q        <= 1'b1;
            oe_q         <= 1'b0;
            d_out_q      <= 8'h00;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            rdn_q        <= rdn_d;
            wrn_q        <= wrn_d;
            oe_q         <= oe_d;
            d_out_q      <= d_out_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
        end
    end

    assign usb_rdn   = rdn_q;
    assign usb_wrn   = wrn_q;
    assign usb_d_oe  = oe_q;
    assign usb_d_out = d_out_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign tx_ready  = grant_wr;

endmodule
